// File: rtl/shift_req_sequencer_if.sv
// Request/result handshake bundle for the shift request sequencer.
// master = producer/consumer side, slave = sequencer side.
interface shift_req_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_shift;
  logic       in_dir;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_data, in_shift, in_dir, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shift, in_dir, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_req_sequencer.sv
// Request FIFO feeding an external combinational barrel shifter, with a
// registered valid/ready result stage behind it.
module shift_req_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_req_sequencer_if.slave   bus,
  output logic [7:0]             sh_data,
  output logic [2:0]             sh_shift,
  output logic                   sh_dir,
  input  logic [7:0]             sh_result,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] shift;
    logic       dir;
  } req_t;

  req_t          mem_q [DEPTH];
  req_t          head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          empty, push, load;

  // in_ready looks only at the count, so a full FIFO never takes a request
  // even in a cycle where the head pops.
  assign bus.in_ready  = (count_q != CW'(DEPTH));
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign fifo_count    = count_q;

  assign empty = (count_q == '0);
  assign push  = bus.in_valid && bus.in_ready;
  assign load  = !empty && (!out_valid_q || bus.out_ready);

  assign head     = mem_q[rd_ptr_q];
  assign sh_data  = empty ? 8'h00 : head.data;
  assign sh_shift = empty ? 3'd0  : head.shift;
  assign sh_dir   = empty ? 1'b0  : head.dir;

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = load ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = sh_result;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= '{data: bus.in_data, shift: bus.in_shift, dir: bus.in_dir};
  end
endmodule

// File: tb/tb_shift_req_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based transaction model of the sequencer.
module tb_shift_req_sequencer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] data;
    logic [2:0] shift;
    logic       dir;
  } mreq_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sh_data, sh_result;
  logic [2:0] sh_shift;
  logic       sh_dir;
  logic [2:0] fifo_count;

  shift_req_sequencer_if bus ();

  shift_req_sequencer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sh_data    (sh_data),
    .sh_shift   (sh_shift),
    .sh_dir     (sh_dir),
    .sh_result  (sh_result),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] shf(input logic [7:0] d, input logic [2:0] s, input logic dir);
    int v;
    v = dir ? (int'(d) / (1 << s)) : ((int'(d) * (1 << s)) % 256);
    return 8'(v);
  endfunction

  // Behavioural stand-in for the combinational shifter
  assign sh_result = shf(sh_data, sh_shift, sh_dir);

  int         errors = 0;
  int         checks = 0;
  mreq_t      mq[$];
  logic       mov  = 1'b0;
  logic [7:0] mout = 8'h00;
  logic [7:0] got[$];
  int         acc;
  logic       last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] s, input logic dir);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_shift = s;
    bus.in_dir   = dir;
  endtask

  // One clock: check DUT against model mid-cycle, then advance the model
  task automatic cyc();
    logic  mpush, mload;
    mreq_t r;
    @(negedge clk);
    chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(mov));
    chk("out_data", 32'(bus.out_data), 32'(mout));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("sh_data", 32'(sh_data), mq.size() > 0 ? 32'(mq[0].data) : 32'd0);
    chk("sh_shift", 32'(sh_shift), mq.size() > 0 ? 32'(mq[0].shift) : 32'd0);
    chk("sh_dir", 32'(sh_dir), mq.size() > 0 ? 32'(mq[0].dir) : 32'd0);
    mpush = bus.in_valid && (mq.size() < DEPTH);
    mload = (mq.size() > 0) && (!mov || bus.out_ready);
    last_acc = 1'b0;
    if (rst) begin
      mq.delete();
      mov  = 1'b0;
      mout = 8'h00;
    end else begin
      if (mov && bus.out_ready) got.push_back(mout);
      if (mpush) begin
        acc++;
        last_acc = 1'b1;
      end
      if (mload) begin
        mout = shf(mq[0].data, mq[0].shift, mq[0].dir);
        mov  = 1'b1;
        void'(mq.pop_front());
      end else if (mov && bus.out_ready) begin
        mov = 1'b0;
      end
      if (mpush) begin
        r.data  = bus.in_data;
        r.shift = bus.in_shift;
        r.dir   = bus.in_dir;
        mq.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] bd [4];
    logic [2:0] bs [4];
    logic       bdir [4];
    logic [7:0] be [4];
    logic [7:0] nxt;
    bd = '{8'hF0, 8'hCC, 8'h1F, 8'hAA};
    bs = '{3'd4, 3'd1, 3'd2, 3'd0};
    bdir = '{1'b1, 1'b0, 1'b1, 1'b1};
    be = '{8'h0F, 8'h98, 8'h07, 8'hAA};

    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    acc = 0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single request latency
    drive(1'b1, 8'hF0, 3'd1, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    cyc();
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_data", 32'(bus.out_data), 32'hE0);
    chk("lat_count", 32'(fifo_count), 32'd0);
    bus.out_ready = 1'b1;
    cyc();

    // Burst, one result per cycle
    got.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, bd[i], bs[i], bdir[i]);
      cyc();
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    repeat (3) cyc();
    chk("burst_n", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("burst_res", 32'(got[i]), 32'(be[i]));

    // Backpressure: DEPTH+1 held
    bus.out_ready = 1'b0;
    got.delete();
    acc = 0;
    nxt = 8'h01;
    repeat (8) begin
      drive(1'b1, nxt, 3'd0, 1'b0);
      cyc();
      if (last_acc) nxt++;
    end
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_count", 32'(fifo_count), 32'd4);
    chk("bp_out_data", 32'(bus.out_data), 32'h01);
    bus.out_ready = 1'b1;
    repeat (10) begin
      if (nxt <= 8'h06) drive(1'b1, nxt, 3'd0, 1'b0);
      else drive(1'b0, 8'h00, 3'd0, 1'b0);
      cyc();
      if (last_acc) nxt++;
    end
    chk("bp_n", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("bp_res", 32'(got[i]), 32'(i + 1));

    // Full boundary: pop cycle blocks the push, next cycle takes it
    bus.out_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h10 + i), 3'd0, 1'b0);
      cyc();
    end
    chk("full_count", 32'(fifo_count), 32'd4);
    drive(1'b1, 8'h15, 3'd0, 1'b0);
    bus.out_ready = 1'b1;
    cyc();
    chk("full_no_push", 32'(last_acc), 32'd0);
    chk("full_count_3", 32'(fifo_count), 32'd3);
    bus.out_ready = 1'b0;
    cyc();
    chk("full_push", 32'(last_acc), 32'd1);
    chk("full_count_4", 32'(fifo_count), 32'd4);
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    bus.out_ready = 1'b1;
    repeat (7) cyc();
    chk("full_n", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("full_res", 32'(got[i]), 32'(8'h10 + i));

    // Mid-operation reset
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h30 + i), 3'd1, 1'b1);
      cyc();
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    chk("mr_pre_valid", 32'(bus.out_valid), 32'd1);
    chk("mr_pre_count", 32'(fifo_count), 32'd3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_out_data", 32'(bus.out_data), 32'd0);
    chk("mr_count", 32'(fifo_count), 32'd0);
    chk("mr_sh_data", 32'(sh_data), 32'd0);
    chk("mr_sh_shift", 32'(sh_shift), 32'd0);
    chk("mr_sh_dir", 32'(sh_dir), 32'd0);
    chk("mr_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    got.delete();
    repeat (3) cyc();
    chk("mr_no_stale", 32'(got.size()), 32'd0);

    // Empty-FIFO drain
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h81, 3'd7, 1'b1);
    cyc();
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    cyc();
    chk("dr_valid", 32'(bus.out_valid), 32'd1);
    chk("dr_data", 32'(bus.out_data), 32'h01);
    bus.out_ready = 1'b1;
    cyc();
    chk("dr_fall", 32'(bus.out_valid), 32'd0);
    chk("dr_sh_data", 32'(sh_data), 32'd0);
    chk("dr_sh_shift", 32'(sh_shift), 32'd0);

    // Random traffic against the model
    repeat (400) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), 1'($urandom));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    bus.out_ready = 1'b1;
    repeat (8) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_req_sequencer.md
# shift_req_sequencer

Upstream feeder stage for the 8-bit combinational barrel shifter. Accepts shift requests (operand, amount, direction) over a valid/ready handshake, buffers them in a small FIFO, presents the head request to the shifter, and registers the shifter result into a valid/ready output stage. It decouples bursty producers from consumers and gives the shifter a registered, back-pressurable datapath.

## Interface
- DEPTH, 4: request FIFO entries; power of two, minimum 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  FIFO can accept; high when FIFO count < DEPTH.
- in_data  input  8  operand.
- in_shift  input  3  shift amount, 0-7.
- in_dir  input  1  0 = logical left, 1 = logical right.
- sh_data  output  8  to shifter data_in; head entry operand.
- sh_shift  output  3  to shifter shift.
- sh_dir  output  1  to shifter dir.
- sh_result  input  8  from shifter data_out; combinational function of sh_*.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer accepts result.
- out_data  output  8  registered result.
- fifo_count  output  $clog2(DEPTH)+1  entries currently in FIFO.

## Operation
- Shifter contract: logical shift, zero fill; dir=0 left, dir=1 right; shift 0 passes through.
- Push: in_valid && in_ready at an edge writes {in_data,in_shift,in_dir} at the write pointer; write pointer advances mod DEPTH.
- in_ready depends only on fifo_count (no pass-through when full, even if a pop occurs the same cycle).
- sh_data/sh_shift/sh_dir are driven from the head entry when fifo_count > 0; all zero when the FIFO is empty.
- Load condition: fifo_count > 0 && (!out_valid || out_ready). On load: out_data <= sh_result, out_valid <= 1, head pops, read pointer advances mod DEPTH.
- Drain without load: out_valid && out_ready && fifo_count == 0 sets out_valid <= 0 and holds out_data.
- Simultaneous push and pop: fifo_count unchanged; both pointers advance.
- Request order is preserved; no request is dropped or duplicated.
- in_valid without in_ready: request is not taken; producer holds it.
- Reset: fifo_count, both pointers, out_valid, out_data and sh_* all go to 0. FIFO contents are discarded. Reset overrides any push or pop in the same cycle.

## Timing
- Latency: request accepted at edge N into an empty FIFO with an empty output register gives out_valid = 1 and the correct out_data after edge N+1.
- Throughput: one result per cycle with in_valid and out_ready held high.
- out_data and out_valid are registered only. sh_* are registered state plus mux (no path from in_* to sh_*). in_ready is registered state only.
- Capacity under full backpressure: DEPTH FIFO entries plus 1 in the output register, so DEPTH+1 requests.
- out_data remains stable while out_valid && !out_ready.

## Test plan
- Reset, then push {11110000, 1, left}; after 2 edges: out_valid=1, out_data=11100000; fifo_count=0.
- Burst with out_ready=1: push {11110000,4,right}, {11001100,1,left}, {00011111,2,right}, {10101010,0,right} on consecutive cycles. Required: consecutive results 00001111, 10011000, 00000111, 10101010, one per cycle, in order.
- Backpressure: out_ready=0, in_valid held high with distinct operands 01..06 (shift 0). Required: exactly 5 accepted, in_ready=0 with fifo_count=4, out_data=01 stable. Then release out_ready: results 01..05 in order; 06 is accepted once in_ready returns.
- Full boundary: FIFO full with out_ready=1 and in_valid=1. Required: no push in the pop cycle; the push occurs on the next cycle; fifo_count goes 4→3→4; write pointer wraps correctly.
- Mid-operation reset: 3 entries queued and out_valid=1, assert rst for one cycle. Required: out_valid=0, out_data=0, fifo_count=0, sh_*=0, in_ready=1, with no stale result afterwards.
- Empty-FIFO drain: single result pending, out_ready=1, no input. Required: out_valid falls after one edge and sh_* read 0.
